cordic_angle_sequencer: RTL and testbench

//  Generates the per-iteration CORDIC micro-rotation stream {shift, angle, last} for one run.

---
 rtl/cordic_angle_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_cordic_angle_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_angle_sequencer.sv
// Per-iteration CORDIC micro-rotation generator: streams {shift, angle, last} beats for
// circular, hyperbolic and linear runs over a registered valid/ready interface.
module cordic_angle_sequencer #(
  parameter int p_WIDTH            = 32,
  parameter int p_ANGLE_ADDR_WIDTH = 5,
  parameter int p_ITER_WIDTH       = 6
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [p_ITER_WIDTH-1:0]       iterCount,
  input  logic                          abort,
  output logic                          angleValid,
  input  logic                          angleReady,
  output logic [p_WIDTH-1:0]            angle,
  output logic [p_ANGLE_ADDR_WIDTH-1:0] shift,
  output logic                          last,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [1:0] MODE_CIRC = 2'b00;
  localparam logic [1:0] MODE_HYP  = 2'b01;
  localparam logic [1:0] MODE_LIN  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam logic [p_ANGLE_ADDR_WIDTH-1:0] SHIFT_MAX = '1;
  localparam logic [p_ANGLE_ADDR_WIDTH-1:0] SHIFT_ONE = p_ANGLE_ADDR_WIDTH'(1);
  localparam logic [p_ITER_WIDTH-1:0]       ITER_ONE  = p_ITER_WIDTH'(1);

  // atan(2^-i) scaled so that 2^32 is one full turn, truncated
  function automatic logic [31:0] circAtan(input logic [4:0] idx);
    logic [31:0] v;
    case (idx)
      5'd0:    v = 32'h2000_0000;
      5'd1:    v = 32'h12E4_051D;
      5'd2:    v = 32'h09FB_385B;
      5'd3:    v = 32'h0511_11D4;
      5'd4:    v = 32'h028B_0D43;
      5'd5:    v = 32'h0145_D7E1;
      5'd6:    v = 32'h00A2_F61E;
      5'd7:    v = 32'h0051_7C55;
      5'd8:    v = 32'h0028_BE53;
      5'd9:    v = 32'h0014_5F2E;
      5'd10:   v = 32'h000A_2F98;
      5'd11:   v = 32'h0005_17CC;
      5'd12:   v = 32'h0002_8BE6;
      5'd13:   v = 32'h0001_45F3;
      5'd14:   v = 32'h0000_A2F9;
      5'd15:   v = 32'h0000_517C;
      5'd16:   v = 32'h0000_28BE;
      5'd17:   v = 32'h0000_145F;
      5'd18:   v = 32'h0000_0A2F;
      5'd19:   v = 32'h0000_0517;
      5'd20:   v = 32'h0000_028B;
      5'd21:   v = 32'h0000_0145;
      5'd22:   v = 32'h0000_00A2;
      5'd23:   v = 32'h0000_0051;
      5'd24:   v = 32'h0000_0028;
      5'd25:   v = 32'h0000_0014;
      5'd26:   v = 32'h0000_000A;
      5'd27:   v = 32'h0000_0005;
      5'd28:   v = 32'h0000_0002;
      5'd29:   v = 32'h0000_0001;
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  // atanh(2^-i) in Q1.31; from i=10 the cubic term is below one LSB so it equals 2^-i
  function automatic logic [31:0] hypAtanh(input logic [4:0] idx);
    logic [31:0] v;
    case (idx)
      5'd0:    v = 32'h0000_0000;
      5'd1:    v = 32'h464F_A9EA;
      5'd2:    v = 32'h20B1_5DF5;
      5'd3:    v = 32'h1015_891C;
      5'd4:    v = 32'h0802_AC45;
      5'd5:    v = 32'h0400_5562;
      5'd6:    v = 32'h0200_0AAB;
      5'd7:    v = 32'h0100_0155;
      5'd8:    v = 32'h0080_002A;
      5'd9:    v = 32'h0040_0005;
      default: v = 32'h8000_0000 >> idx;
    endcase
    return v;
  endfunction

  function automatic logic [p_WIDTH-1:0] angleEntry(input logic [1:0] m, input logic [4:0] idx);
    logic [31:0] full;
    case (m)
      MODE_CIRC: full = circAtan(idx);
      MODE_HYP:  full = hypAtanh(idx);
      MODE_LIN:  full = 32'h8000_0000 >> idx;
      default:   full = 32'h0000_0000;
    endcase
    return p_WIDTH'(full >> (32 - p_WIDTH));
  endfunction

  state_e                          state_q, state_d;
  logic [1:0]                      mode_q, mode_d;
  logic [p_ITER_WIDTH-1:0]         iterTarget_q, iterTarget_d;
  logic [p_ITER_WIDTH-1:0]         beatNum_q, beatNum_d;
  logic [p_ANGLE_ADDR_WIDTH-1:0]   shift_q, shift_d;
  logic                            repDone_q, repDone_d;
  logic [p_WIDTH-1:0]              angle_q, angle_d;
  logic                            last_q, last_d;
  logic [p_ANGLE_ADDR_WIDTH-1:0]   nextShift;
  logic                            repeatPoint;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_CIRC;
      iterTarget_q <= '0;
      beatNum_q    <= '0;
      shift_q      <= '0;
      repDone_q    <= 1'b0;
      angle_q      <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      iterTarget_q <= iterTarget_d;
      beatNum_q    <= beatNum_d;
      shift_q      <= shift_d;
      repDone_q    <= repDone_d;
      angle_q      <= angle_d;
      last_q       <= last_d;
    end
  end

  // Hyperbolic convergence needs shifts 4 and 13 issued twice; repDone marks the second issue
  assign repeatPoint = (mode_q == MODE_HYP) && !repDone_q &&
                       ((5'(shift_q) == 5'd4) || (5'(shift_q) == 5'd13));

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    iterTarget_d = iterTarget_q;
    beatNum_d    = beatNum_q;
    shift_d      = shift_q;
    repDone_d    = repDone_q;
    angle_d      = angle_q;
    last_d       = last_q;
    nextShift    = shift_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && (mode != MODE_RSVD)) begin
          mode_d       = mode;
          iterTarget_d = iterCount;
          if (iterCount == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_RUN;
            nextShift = (mode == MODE_HYP) ? SHIFT_ONE : '0;
            shift_d   = nextShift;
            repDone_d = 1'b0;
            beatNum_d = ITER_ONE;
            last_d    = (iterCount == ITER_ONE);
            angle_d   = angleEntry(mode, 5'(nextShift));
          end
        end
      end

      ST_RUN: begin
        if (abort || (angleReady && last_q)) begin
          state_d = abort ? ST_IDLE : ST_DONE;
          shift_d = '0;
          angle_d = '0;
          last_d  = 1'b0;
        end else if (angleReady) begin
          if (repeatPoint) begin
            repDone_d = 1'b1;
          end else if (shift_q != SHIFT_MAX) begin
            nextShift = shift_q + SHIFT_ONE;
            repDone_d = 1'b0;
          end
          shift_d   = nextShift;
          beatNum_d = beatNum_q + ITER_ONE;
          last_d    = ((beatNum_q + ITER_ONE) == iterTarget_q);
          angle_d   = angleEntry(mode_q, 5'(nextShift));
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign angleValid = (state_q == ST_RUN);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign angle      = angle_q;
  assign shift      = shift_q;
  assign last       = last_q;

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Directed and randomized runs of cordic_angle_sequencer (32- and 16-bit angle instances)
// against a math-derived reference of the shift sequence and angle tables.
module tb_cordic_angle_sequencer;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [1:0]  mode;
  logic [5:0]  iterCount;
  logic        abort;
  logic        angleReady;
  logic        angleValid, last, busy, done;
  logic [31:0] angle;
  logic [4:0]  shift;
  logic        angleValid16, last16, busy16, done16;
  logic [15:0] angle16;
  logic [4:0]  shift16;

  int checks = 0;
  int errors = 0;

  cordic_angle_sequencer #(.p_WIDTH(32), .p_ANGLE_ADDR_WIDTH(5), .p_ITER_WIDTH(6)) dut (
    .clk(clk), .rstN(rstN), .start(start), .mode(mode), .iterCount(iterCount),
    .abort(abort), .angleValid(angleValid), .angleReady(angleReady), .angle(angle),
    .shift(shift), .last(last), .busy(busy), .done(done)
  );

  cordic_angle_sequencer #(.p_WIDTH(16), .p_ANGLE_ADDR_WIDTH(5), .p_ITER_WIDTH(6)) dut16 (
    .clk(clk), .rstN(rstN), .start(start), .mode(mode), .iterCount(iterCount),
    .abort(abort), .angleValid(angleValid16), .angleReady(angleReady), .angle(angle16),
    .shift(shift16), .last(last16), .busy(busy16), .done(done16)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Shift of the k-th beat (0-based); hyperbolic walks 1.. with 4 and 13 issued twice
  function automatic int modelShift(input int m, input int k);
    int s;
    int pos;
    int reps;
    if (m != 1) return (k > 31) ? 31 : k;
    s = 1;
    pos = 0;
    for (int guard = 0; guard < 64; guard++) begin
      reps = (s == 4 || s == 13) ? 2 : 1;
      if (k < pos + reps) return s;
      pos += reps;
      if (s == 31) return 31;
      s++;
    end
    return 31;
  endfunction

  function automatic logic [31:0] modelAngle(input int m, input int s);
    real x;
    real v;
    x = 1.0;
    for (int i = 0; i < s; i++) x = x / 2.0;
    if (m == 2) return 32'h8000_0000 >> s;
    if (m == 1) begin
      if (s == 0) return 32'd0;
      v = $atanh(x) * 2147483648.0;
    end else begin
      v = $atan(x) / (2.0 * PI) * 4294967296.0;
    end
    return 32'(longint'($floor(v + 1.0e-5)));
  endfunction

  task automatic checkBeat(input string tag, input int m, input int k, input int n);
    int          s;
    logic [31:0] a;
    s = modelShift(m, k);
    a = modelAngle(m, s);
    checkOutput($sformatf("%s/b%0d/valid", tag, k), 64'(angleValid), 64'd1);
    checkOutput($sformatf("%s/b%0d/busy", tag, k), 64'(busy), 64'd1);
    checkOutput($sformatf("%s/b%0d/done", tag, k), 64'(done), 64'd0);
    checkOutput($sformatf("%s/b%0d/shift", tag, k), 64'(shift), 64'(s));
    checkOutput($sformatf("%s/b%0d/last", tag, k), 64'(last), 64'(k == n - 1));
    checkOutput($sformatf("%s/b%0d/angle", tag, k), 64'(angle), 64'(a));
    checkOutput($sformatf("%s/b%0d/valid16", tag, k), 64'(angleValid16), 64'd1);
    checkOutput($sformatf("%s/b%0d/shift16", tag, k), 64'(shift16), 64'(s));
    checkOutput($sformatf("%s/b%0d/last16", tag, k), 64'(last16), 64'(k == n - 1));
    checkOutput($sformatf("%s/b%0d/angle16", tag, k), 64'(angle16), 64'(a >> 16));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "/valid"}, 64'(angleValid), 64'd0);
    checkOutput({tag, "/busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "/done"}, 64'(done), 64'd0);
    checkOutput({tag, "/last"}, 64'(last), 64'd0);
    checkOutput({tag, "/busy16"}, 64'(busy16), 64'd0);
    checkOutput({tag, "/done16"}, 64'(done16), 64'd0);
  endtask

  // One run: stallPct = chance of ready low, stallBeat = beat held 3 cycles, abortAt = beat aborted
  task automatic applyStimulus(input string tag, input int m, input int n, input int stallPct,
                               input int stallBeat, input int abortAt);
    int k;
    int cyc;
    int held;
    bit xfer;
    k = 0;
    cyc = 0;
    held = 0;
    mode = 2'(m);
    iterCount = 6'(n);
    start = 1'b1;
    abort = 1'b0;
    angleReady = ($urandom_range(99) >= stallPct);
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'($urandom);
    iterCount = 6'($urandom);
    if (m == 3) begin
      repeat (3) begin
        checkIdle({tag, "/rsvd"});
        @(posedge clk); #1;
      end
      return;
    end
    if (k == stallBeat && held < 3) begin angleReady = 1'b0; held++; end
    while (k < n && cyc < 4000) begin
      checkBeat(tag, m, k, n);
      if (k == abortAt) begin
        abort = 1'b1;
        angleReady = 1'b1;
      end
      xfer = angleReady;
      start = ($urandom_range(3) == 0);
      @(posedge clk); #1;
      cyc++;
      if (abort) begin
        abort = 1'b0;
        start = 1'b0;
        checkIdle({tag, "/abort"});
        @(posedge clk); #1;
        checkIdle({tag, "/abort+1"});
        return;
      end
      if (xfer) k++;
      if (k == stallBeat && held < 3) begin
        angleReady = 1'b0;
        held++;
      end else begin
        angleReady = ($urandom_range(99) >= stallPct);
      end
    end
    checkOutput({tag, "/beats"}, 64'(k), 64'(n));
    checkOutput({tag, "/done"}, 64'(done), 64'd1);
    checkOutput({tag, "/done16"}, 64'(done16), 64'd1);
    checkOutput({tag, "/doneBusy"}, 64'(busy), 64'd1);
    checkOutput({tag, "/doneValid"}, 64'(angleValid), 64'd0);
    checkOutput({tag, "/doneLast"}, 64'(last), 64'd0);
    start = 1'b1;
    mode = 2'b00;
    iterCount = 6'd1;
    @(posedge clk); #1;
    start = 1'b0;
    checkIdle({tag, "/afterDone"});
  endtask

  initial begin
    int m;
    int n;
    int ab;
    rstN = 1'b0;
    start = 1'b0;
    mode = 2'b00;
    iterCount = 6'd0;
    abort = 1'b0;
    angleReady = 1'b0;
    #12;
    checkIdle("reset");
    checkOutput("reset/angle", 64'(angle), 64'd0);
    checkOutput("reset/shift", 64'(shift), 64'd0);
    rstN = 1'b1;
    @(posedge clk); #1;

    applyStimulus("T1circ3", 0, 3, 0, -1, -1);
    applyStimulus("T2hyp6", 1, 6, 0, -1, -1);
    applyStimulus("T3linStall", 2, 4, 0, 1, -1);
    applyStimulus("T4circ2", 0, 2, 0, -1, -1);
    applyStimulus("T5zero", 0, 0, 0, -1, -1);
    applyStimulus("T5rsvd", 3, 5, 0, -1, -1);
    applyStimulus("T6abort", 0, 5, 0, -1, 1);
    applyStimulus("T6sat", 0, 40, 0, -1, -1);
    applyStimulus("hypSat", 1, 63, 25, -1, -1);
    applyStimulus("abortLast", 2, 3, 0, -1, 2);

    // Asynchronous reset in the middle of a run
    mode = 2'b00;
    iterCount = 6'd10;
    start = 1'b1;
    angleReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkIdle("midReset");
    checkOutput("midReset/angle", 64'(angle), 64'd0);
    checkOutput("midReset/shift", 64'(shift), 64'd0);
    #3;
    rstN = 1'b1;
    @(posedge clk); #1;
    checkIdle("postReset");

    for (int r = 0; r < 12; r++) begin
      m = $urandom_range(2);
      n = $urandom_range(63);
      ab = ($urandom_range(3) == 0) ? $urandom_range(63) : -1;
      applyStimulus($sformatf("rand%0d", r), m, n, $urandom_range(60), -1, ab);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
